// File: rtl/canvas_ram_arbiter.sv
// Canvas RAM arbiter: shares the single-port canvas RAM between painter writes, display
// reads and a full-canvas scan stream. Optional macro: CANVAS_ARB_WRITE_LOCK_EN.
//
// state | meaning
// IDLE  | no scan; painter write beats display read
// SCAN  | issuing scan reads, round-robin with display reads
// DRAIN | all scan addresses issued, waiting for the last beat to be accepted
module canvas_ram_arbiter #(
    parameter int CANVAS_SIZE = 784,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_req,
    input  logic [AW-1:0] w_addr,
    input  logic          w_data,
    output logic          w_gnt,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic          d_rdata,
    input  logic          c_start,
    output logic          c_valid,
    input  logic          c_ready,
    output logic          c_data,
    output logic          c_last,
    output logic          c_done,
    output logic          c_busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wdata,
    input  logic          ram_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(CANVAS_SIZE - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] iss_addr_q, iss_addr_d;
    logic          inflight_q, inflight_d;
    logic          inflight_last_q, inflight_last_d;
    logic [1:0]    fifo_count_q, fifo_count_d;
    logic [1:0]    fifo_data_q, fifo_data_d;
    logic [1:0]    fifo_last_q, fifo_last_d;
    logic          rr_disp_q, rr_disp_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic          done_q, done_d;

    logic          w_allow, scan_elig, scan_gnt, pop, push;
    logic [2:0]    occ;

    assign c_valid  = (fifo_count_q != 2'd0);
    assign c_data   = c_valid & fifo_data_q[0];
    assign c_last   = c_valid & fifo_last_q[0];
    assign c_busy   = (state_q != ST_IDLE);
    assign c_done   = done_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rvalid_q & ram_rdata;

    assign pop  = c_valid & c_ready;
    assign push = inflight_q;
    // Occupancy counts reads still in flight so a full FIFO is never overrun.
    assign occ       = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign scan_elig = (state_q == ST_SCAN) && (occ < 3'd2);

`ifdef CANVAS_ARB_WRITE_LOCK_EN
    assign w_allow = (state_q == ST_IDLE);
`else
    assign w_allow = 1'b1;
`endif

    always_comb begin
        w_gnt    = w_req & w_allow;
        d_gnt    = 1'b0;
        scan_gnt = 1'b0;
        if (!w_gnt) begin
            if (state_q == ST_SCAN) begin
                if (scan_elig && d_req) begin
                    d_gnt    = rr_disp_q;
                    scan_gnt = !rr_disp_q;
                end else begin
                    d_gnt    = d_req;
                    scan_gnt = scan_elig;
                end
            end else begin
                d_gnt = d_req;
            end
        end

        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 1'b0;
        if (w_gnt) begin
            ram_we    = 1'b1;
            ram_addr  = w_addr;
            ram_wdata = w_data;
        end else if (d_gnt) begin
            ram_addr = d_addr;
        end else if (scan_gnt) begin
            ram_addr = iss_addr_q;
        end
    end

    always_comb begin
        state_d         = state_q;
        iss_addr_d      = iss_addr_q;
        inflight_d      = scan_gnt;
        inflight_last_d = scan_gnt && (iss_addr_q == LAST_ADDR);
        rr_disp_d       = rr_disp_q;
        d_rvalid_d      = d_gnt;
        done_d          = 1'b0;
        fifo_count_d    = fifo_count_q;
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;

        case (state_q)
            ST_IDLE: begin
                if (c_start) begin
                    state_d    = ST_SCAN;
                    iss_addr_d = '0;
                end
            end
            ST_SCAN: begin
                if (scan_gnt) begin
                    rr_disp_d = 1'b1;
                    if (iss_addr_q == LAST_ADDR) begin
                        iss_addr_d = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        iss_addr_d = iss_addr_q + AW'(1);
                    end
                end else if (d_gnt) begin
                    rr_disp_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (pop && c_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Two-slot shift FIFO: slot 0 is the head.
        case ({push, pop})
            2'b01: begin
                fifo_data_d[0] = fifo_data_q[1];
                fifo_last_d[0] = fifo_last_q[1];
                fifo_count_d   = fifo_count_q - 2'd1;
            end
            2'b10: begin
                if (fifo_count_q == 2'd0) begin
                    fifo_data_d[0] = ram_rdata;
                    fifo_last_d[0] = inflight_last_q;
                end else begin
                    fifo_data_d[1] = ram_rdata;
                    fifo_last_d[1] = inflight_last_q;
                end
                fifo_count_d = fifo_count_q + 2'd1;
            end
            2'b11: begin
                if (fifo_count_q == 2'd1) begin
                    fifo_data_d[0] = ram_rdata;
                    fifo_last_d[0] = inflight_last_q;
                end else begin
                    fifo_data_d[0] = fifo_data_q[1];
                    fifo_last_d[0] = fifo_last_q[1];
                    fifo_data_d[1] = ram_rdata;
                    fifo_last_d[1] = inflight_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            iss_addr_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_count_q    <= 2'd0;
            fifo_data_q     <= 2'b00;
            fifo_last_q     <= 2'b00;
            rr_disp_q       <= 1'b0;
            d_rvalid_q      <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            iss_addr_q      <= iss_addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_count_q    <= fifo_count_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            rr_disp_q       <= rr_disp_d;
            d_rvalid_q      <= d_rvalid_d;
            done_q          <= done_d;
        end
    end

endmodule

// File: tb/tb_canvas_ram_arbiter.sv
// Self-checking bench for canvas_ram_arbiter: IDLE arbitration vectors plus scan sequences.
module tb_canvas_ram_arbiter;

    localparam int CS = 784;
    localparam int AW = 10;
`ifdef CANVAS_ARB_WRITE_LOCK_EN
    localparam logic W_EXP = 1'b0;
`else
    localparam logic W_EXP = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic w_req = 0, w_data = 0, d_req = 0, c_start = 0, c_ready = 1;
    logic [AW-1:0] w_addr = '0, d_addr = '0;
    logic w_gnt, d_gnt, d_rvalid, d_rdata, c_valid, c_data, c_last, c_done, c_busy;
    logic ram_we, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    canvas_ram_arbiter #(.CANVAS_SIZE(CS), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .c_start(c_start), .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
        .c_last(c_last), .c_done(c_done), .c_busy(c_busy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Synchronous single-port RAM model
    logic mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {w_gnt, d_gnt, d_rvalid, d_rdata, c_valid, c_data, c_last,
                                c_done, c_busy, ram_we, ram_wdata}, 0);
        check({tag, "_ram_addr"}, int'(ram_addr), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic          w_req;
        logic [AW-1:0] w_addr;
        logic          w_data;
        logic          d_req;
        logic [AW-1:0] d_addr;
        logic          e_wgnt;
        logic          e_dgnt;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic          e_wdata;
        logic          e_rvalid;
        logic          e_rdata;
    } vec_t;

    // mode 0: ready=1; 1: d_req held at addr 10; 2: random ready; 3: painter write at addr 0
    task automatic run_scan(input int mode, input string tag);
        int beats = 0, cyc = 0, first_valid = -1, last_cyc = -1, done_cyc = -1;
        int data_errs = 0, last_errs = 0, stall_errs = 0, alt_errs = 0, rv_errs = 0;
        int wg_errs = 0, ovf_errs = 0, early_done = 0;
        logic prev_stall = 0, prev_data = 0, prev_last = 0, prev_dgnt = 0;
        c_start = 1'b1; c_ready = 1'b1; d_req = 1'b0; w_req = 1'b0;
        while (done_cyc < 0 && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            c_start = 1'b0; c_ready = 1'b1;
            d_req = 1'b0; d_addr = '0; w_req = 1'b0; w_addr = '0; w_data = 1'b0;
            if (mode == 1) begin d_req = 1'b1; d_addr = 10'd10; end
            if (mode == 2) c_ready = (cyc >= 200 && cyc < 220) ? 1'b0 : 1'($urandom_range(0, 1));
            if (mode == 3 && cyc >= 50 && cyc < 55) begin w_req = 1'b1; w_addr = '0; w_data = 1'b1; end
            #1;
            if (prev_stall && (!c_valid || c_data != prev_data || c_last != prev_last)) stall_errs++;
            if (mode == 3 && cyc >= 50 && cyc < 55 && w_gnt != W_EXP) wg_errs++;
            if (mode == 1) begin
                if (cyc <= 2 * CS - 1 && d_gnt != (cyc % 2 == 0)) alt_errs++;
                if (d_rvalid != prev_dgnt || (d_rvalid && d_rdata != 1'b0)) rv_errs++;
            end
            if (dut.fifo_count_q > 2'd2) ovf_errs++;
            if (c_valid && first_valid < 0) first_valid = cyc;
            if (c_valid && c_ready) begin
                if (c_data != beats[0]) data_errs++;
                if (c_last != (beats == CS - 1)) last_errs++;
                if (c_last) last_cyc = cyc;
                beats++;
            end
            if (c_done) begin
                if (beats != CS) early_done++;
                done_cyc = cyc;
            end
            prev_stall = c_valid && !c_ready;
            prev_data = c_data; prev_last = c_last; prev_dgnt = d_gnt;
        end
        c_ready = 1'b1; d_req = 1'b0; w_req = 1'b0; w_data = 1'b0;
        check({tag, "_finished"}, int'(done_cyc >= 0), 1);
        check({tag, "_beats"}, beats, CS);
        check({tag, "_data_errs"}, data_errs, 0);
        check({tag, "_last_errs"}, last_errs, 0);
        check({tag, "_stall_errs"}, stall_errs, 0);
        check({tag, "_fifo_ovf"}, ovf_errs, 0);
        check({tag, "_early_done"}, early_done, 0);
        if (mode == 0) begin
            check({tag, "_first_valid_cyc"}, first_valid, 3);
            check({tag, "_last_cyc"}, last_cyc, 786);
            check({tag, "_done_cyc"}, done_cyc, 787);
        end
        if (mode == 1) begin
            check({tag, "_alternation_errs"}, alt_errs, 0);
            check({tag, "_rvalid_errs"}, rv_errs, 0);
        end
        if (mode == 3) check({tag, "_w_gnt_errs"}, wg_errs, 0);
        @(posedge clk); #1;
        check({tag, "_busy_after"}, int'(c_busy), 0);
        check({tag, "_done_pulse_len"}, int'(c_done), 0);
    endtask

    vec_t vecs [9];

    initial begin
        int beats;
        int dones;
        vecs[0] = '{1'b1, 10'd5,   1'b1, 1'b1, 10'd5,   1'b1, 1'b0, 1'b1, 10'd5,   1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 10'd0,   1'b0, 1'b1, 10'd5,   1'b0, 1'b1, 1'b0, 10'd5,   1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 10'd7,   1'b0, 1'b0, 10'd0,   1'b1, 1'b0, 1'b1, 10'd7,   1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 10'd0,   1'b0, 1'b1, 10'd7,   1'b0, 1'b1, 1'b0, 10'd7,   1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 10'd7,   1'b1, 1'b0, 10'd0,   1'b1, 1'b0, 1'b1, 10'd7,   1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 10'd0,   1'b0, 1'b1, 10'd7,   1'b0, 1'b1, 1'b0, 10'd7,   1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 10'd0,   1'b0, 1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 10'd783, 1'b1, 1'b1, 10'd0,   1'b1, 1'b0, 1'b1, 10'd783, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 10'd0,   1'b0, 1'b1, 10'd783, 1'b0, 1'b1, 1'b0, 10'd783, 1'b0, 1'b1, 1'b1};

        #1;
        check_all_zero("reset_held");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_all_zero("reset_released");

        for (int i = 0; i < 9; i++) begin
            w_req = vecs[i].w_req; w_addr = vecs[i].w_addr; w_data = vecs[i].w_data;
            d_req = vecs[i].d_req; d_addr = vecs[i].d_addr;
            #1;
            check($sformatf("vec%0d_w_gnt", i), int'(w_gnt), int'(vecs[i].e_wgnt));
            check($sformatf("vec%0d_d_gnt", i), int'(d_gnt), int'(vecs[i].e_dgnt));
            check($sformatf("vec%0d_ram_we", i), int'(ram_we), int'(vecs[i].e_we));
            check($sformatf("vec%0d_ram_addr", i), int'(ram_addr), int'(vecs[i].e_addr));
            check($sformatf("vec%0d_ram_wdata", i), int'(ram_wdata), int'(vecs[i].e_wdata));
            @(posedge clk); #1;
            check($sformatf("vec%0d_d_rvalid", i), int'(d_rvalid), int'(vecs[i].e_rvalid));
            check($sformatf("vec%0d_d_rdata", i), int'(d_rdata), int'(vecs[i].e_rdata));
        end
        d_req = 1'b0;

        // Load pixel[i] = i[0] through painter writes
        for (int i = 0; i < CS; i++) begin
            w_req = 1'b1; w_addr = AW'(i); w_data = i[0];
            @(posedge clk); #1;
        end
        w_req = 1'b0; w_data = 1'b0;

        run_scan(0, "scan_plain");

        // Reset in the middle of a scan, after beat 100 is accepted
        beats = 0;
        c_start = 1'b1; c_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && beats <= 100; cyc++) begin
            @(posedge clk); #1;
            c_start = 1'b0;
            #1;
            if (c_valid && c_ready) beats++;
        end
        check("midscan_reached_beat100", beats, 101);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midscan_rst_c_valid", int'(c_valid), 0);
        check("midscan_rst_c_busy", int'(c_busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (c_done || c_valid) dones++;
            @(posedge clk); #1;
        end
        check("midscan_no_done_or_valid", dones, 0);
        run_scan(0, "scan_after_reset");

        do_reset();
        run_scan(1, "scan_with_dreq");

        run_scan(2, "scan_random_ready");

        run_scan(3, "scan_with_write");
        d_req = 1'b1; d_addr = '0;
        @(posedge clk); #1;
        d_req = 1'b0;
        #1;
        check("write_during_scan_rvalid", int'(d_rvalid), 1);
        check("write_during_scan_pixel0", int'(d_rdata), int'(W_EXP));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/canvas_ram_arbiter.md
# canvas_ram_arbiter

Shares the single-port 784×1-bit canvas RAM between three requesters: the mouse painter (writes), the VGA display (random reads) and the classifier (full-canvas read stream). It owns the RAM port and grants one access per cycle. On request it runs a scan engine that streams all canvas pixels, in address order, to the classifier over a valid/ready handshake with backpressure.

## Interface
Parameters:
- CANVAS_SIZE, 784, number of pixels (28×28); scan covers addresses 0..CANVAS_SIZE-1
- AW, 10, address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- w_req  in  1  painter write request
- w_addr  in  AW  painter write address
- w_data  in  1  painter write data
- w_gnt  out  1  write performed this cycle (combinational)
- d_req  in  1  display read request
- d_addr  in  AW  display read address
- d_gnt  out  1  display read issued this cycle (combinational)
- d_rvalid  out  1  display read data valid (registered)
- d_rdata  out  1  display read data
- c_start  in  1  start scan (sampled only in IDLE)
- c_valid  out  1  stream beat valid
- c_ready  in  1  classifier accepts beat
- c_data  out  1  pixel value
- c_last  out  1  beat is pixel CANVAS_SIZE-1
- c_done  out  1  one-cycle pulse, scan complete
- c_busy  out  1  state != IDLE
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  1  RAM write data
- ram_rdata  in  1  RAM read data, valid the cycle after the address is presented

## Operation
- States: IDLE, SCAN, DRAIN. IDLE→SCAN when c_start=1. SCAN→DRAIN after address CANVAS_SIZE-1 is issued. DRAIN→IDLE on the c_last handshake. c_done pulses in the cycle after that transition. c_start outside IDLE is ignored.
- Scan engine: issue counter iss_addr (0..CANVAS_SIZE-1), in-flight flag (read issued last cycle), 2-entry output FIFO. FIFO head drives c_valid/c_data. c_last = head is the final pixel.
- Scan issue eligibility: state SCAN and (fifo_count + inflight − pop) < 2, where pop = c_valid & c_ready. With this rule the FIFO never overflows and nothing is lost under backpressure.
- Arbitration, one RAM access per cycle:
  - IDLE: W > D.
  - SCAN: the scan engine and D alternate round-robin on contention. The pointer moves to the other requester after each grant. After reset the pointer favours the scan.
  - DRAIN: D only.
  - W in SCAN/DRAIN: see Configuration.
- A write drives ram_we=1, ram_addr=w_addr, ram_wdata=w_data. A read drives ram_we=0 with the granted address. With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
- Ungranted requests are dropped, not queued. Requesters must re-present them.
- d_rvalid is d_gnt delayed by one cycle. d_rdata=ram_rdata when d_rvalid, else 0.
- Reset values: all outputs 0. State IDLE, FIFO empty, iss_addr=0, inflight=0, RR pointer favours scan.
- Reset mid-scan aborts immediately: no c_done, FIFO contents discarded.

## Timing
- Display read: d_gnt in cycle t → d_rvalid/d_rdata in t+1.
- Scan, c_ready held 1, no d_req:
  - c_start in cycle 0.
  - Address 0 issued in cycle 1.
  - First c_valid in cycle 3.
  - One beat per cycle; c_last in cycle 786, c_done in cycle 787.
- With d_req held 1 during the scan, the scan gets every other cycle, so its throughput is 1/2.
- c_valid, c_data and c_last hold stable while c_valid & !c_ready.
- FIFO push (from ram_rdata) and pop in the same cycle are allowed.

## Configuration
- CANVAS_ARB_WRITE_LOCK_EN defined: in SCAN and DRAIN, w_gnt=0 and painter writes are dropped, so the streamed image is a consistent snapshot.
- Not defined: W has top priority in every state and preempts scan and D issues. The scan stalls, with no address skipped, and the stream may mix pre- and post-write pixels.

## Test plan
- Reset with all requests 0 → every output 0 and c_busy=0. Assert rst mid-scan at beat 100 → c_valid=0 next cycle, no c_done, and a new c_start works.
- IDLE, w_req=1 and d_req=1, both at address 5 → w_gnt=1, d_gnt=0, ram_we=1, ram_addr=5. Then d_req alone → d_rvalid=1 one cycle later with the written data.
- Canvas loaded with pattern pixel[i]=i[0], c_ready=1, no d_req, c_start in cycle 0 → 784 beats in cycles 3..786 matching the pattern, c_last only on beat 783, c_done in cycle 787.
- Scan with d_req=1 throughout (d_addr=10) → issues alternate scan/display, d_rvalid every other cycle, all 784 beats correct.
- c_ready toggled at random plus a 20-cycle low stretch → no lost or duplicated beats, fifo_count ≤ 2, outputs stable while stalled.
- w_req=1 at address 0 during the scan: with the macro defined → w_gnt=0 and RAM unchanged. Without it → w_gnt=1 and the scan still delivers 784 beats in order.
